alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational 32-bit ALU among `NUM_REQ` requesters. It accepts one operation at a time through per-requester valid/ready handshakes and drives the shared ALU's operand and opcode inputs from registers. It samples the ALU result and returns it, tagged with the requester index, on a single valid/ready response channel. It sits between the issuing units and the ALU instance; the ALU itself stays outside this block.

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter/sequencer sharing one external ALU among NUM_REQ requesters
// Optional ALU_ARB_ERR_EN adds resp_error, which flags opcodes outside 1..5.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_operand1,
    input  logic [NUM_REQ*WIDTH-1:0] req_operand2,
    input  logic [NUM_REQ*4-1:0]     req_opcode,
    output logic [WIDTH-1:0]         alu_operand1,
    output logic [WIDTH-1:0]         alu_operand2,
    output logic [3:0]               alu_opcode,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
`ifdef ALU_ARB_ERR_EN
    output logic                     resp_error,
`endif
    output logic [WIDTH-1:0]         resp_result
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] next_ptr;
    logic            grant_found;
    logic            hi_found;
    logic            lo_found;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    logic [WIDTH-1:0] op1_arr [NUM_REQ];
    logic [WIDTH-1:0] op2_arr [NUM_REQ];
    logic [3:0]       opc_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op1_arr[i] = req_operand1[i*WIDTH +: WIDTH];
            op2_arr[i] = req_operand2[i*WIDTH +: WIDTH];
            opc_arr[i] = req_opcode[i*4 +: 4];
        end
    end

    // Lowest requester at or above rr_ptr wins; otherwise lowest below it (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (ID_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                end
            end
        end
        grant_found = hi_found | lo_found;
        winner      = hi_found ? hi_idx : lo_idx;
        next_ptr    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        req_ready   = '0;
        if (state == IDLE && grant_found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_opcode   <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_result  <= '0;
`ifdef ALU_ARB_ERR_EN
            resp_error   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        alu_operand1 <= op1_arr[winner];
                        alu_operand2 <= op2_arr[winner];
                        alu_opcode   <= opc_arr[winner];
                        resp_id      <= winner;
                        rr_ptr       <= next_ptr;
`ifdef ALU_ARB_ERR_EN
                        resp_error   <= !(opc_arr[winner] inside {[4'd1:4'd5]});
`endif
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result <= alu_result;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    // Handshake cycle grants nothing; arbitration resumes from IDLE.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
